// File: rtl/wheel_encoder_reader_pkg.sv
// ============================================================================
// encoder_pkg : shared quadrature constants, step codes and FSM encodings
// Revision    : 1.0
// ============================================================================
`default_nettype none

package encoder_pkg;

  localparam logic [1:0] Q00 = 2'b00;
  localparam logic [1:0] Q01 = 2'b01;
  localparam logic [1:0] Q11 = 2'b11;
  localparam logic [1:0] Q10 = 2'b10;

  localparam logic [1:0] STEP_NONE = 2'd0;
  localparam logic [1:0] STEP_FWD  = 2'd1;
  localparam logic [1:0] STEP_REV  = 2'd2;
  localparam logic [1:0] STEP_ILL  = 2'd3;

  localparam logic [0:0] PRIME = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  localparam int PRIME_CYCLES = 3;

  // Forward rotation order is 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] fwd_next(input logic [1:0] q);
    logic [1:0] n;
    n = Q00;
    case (q)
      Q00:     n = Q01;
      Q01:     n = Q11;
      Q11:     n = Q10;
      default: n = Q00;
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wheel_encoder_reader_if.sv
// ============================================================================
// wheel_encoder_reader_if : encoder pins, controls and measurement outputs
// Revision                : 1.0
// ============================================================================
`default_nettype none

interface wheel_encoder_reader_if #(
  parameter int CNT_W = 16,
  parameter int POS_W = 24
);
  logic             enc_a;
  logic             enc_b;
  logic             clr_pos;
  logic             err_clr;
  logic [POS_W-1:0] pos;
  logic [CNT_W-1:0] speed;
  logic             dir;
  logic             spd_valid;
  logic             stalled;
  logic             enc_err;

  modport master (
    output enc_a, enc_b, clr_pos, err_clr,
    input  pos, speed, dir, spd_valid, stalled, enc_err
  );

  modport slave (
    input  enc_a, enc_b, clr_pos, err_clr,
    output pos, speed, dir, spd_valid, stalled, enc_err
  );
endinterface

`default_nettype wire

// File: rtl/wheel_encoder_reader_quad_step_decode.sv
// ============================================================================
// quad_step_decode : maps (previous, current) quadrature state to a step code
// Revision         : 1.0
// ============================================================================
`default_nettype none

module quad_step_decode
  import encoder_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] cur,
  output logic [1:0] step
);

  always_comb begin
    step = STEP_NONE;
    if (prev == cur)
      step = STEP_NONE;
    else if ((prev ^ cur) == 2'b11)
      step = STEP_ILL;
    else if (cur == fwd_next(prev))
      step = STEP_FWD;
    else
      step = STEP_REV;
  end

endmodule

`default_nettype wire

// File: rtl/wheel_encoder_reader.sv
// ============================================================================
// wheel_encoder_reader : quadrature wheel position, windowed speed and stall
// Revision             : 1.0
// ============================================================================
`default_nettype none

module wheel_encoder_reader
  import encoder_pkg::*;
#(
  parameter int GATE_CYCLES   = 50000,
  parameter int CNT_W         = 16,
  parameter int POS_W         = 24,
  parameter int STALL_WINDOWS = 4
) (
  input  logic                  clk1,
  input  logic                  rst,
  wheel_encoder_reader_if.slave bus
);

  localparam int WIN_W  = $clog2(GATE_CYCLES);
  localparam int IDLE_W = $clog2(STALL_WINDOWS + 1);
  localparam logic signed [CNT_W:0] ACC_MAX = {1'b0, {CNT_W{1'b1}}};
  localparam logic signed [CNT_W:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [CNT_W:0] ONE     = {{CNT_W{1'b0}}, 1'b1};

  logic [1:0]              a_sync, b_sync;
  logic [1:0]              cur_q, prev_q, step_code;
  logic [0:0]              state, state_nxt;
  logic [1:0]              prime_cnt;
  logic                    counting;
  logic                    step_fwd, step_rev, step_ill;
  logic [WIN_W-1:0]        win_cnt;
  logic                    win_end;
  logic signed [CNT_W:0]   acc, acc_next, acc_step, acc_neg;
  logic [CNT_W-1:0]        acc_abs;
  logic [IDLE_W-1:0]       idle_cnt, idle_next;
  logic [POS_W-1:0]        pos;
  logic [CNT_W-1:0]        speed;
  logic                    dir, spd_valid, stalled, enc_err;

  assign cur_q = {a_sync[1], b_sync[1]};

  always_ff @(posedge clk1) begin
    if (rst) begin
      a_sync <= '0;
      b_sync <= '0;
      prev_q <= Q00;
    end else begin
      a_sync <= {a_sync[0], bus.enc_a};
      b_sync <= {b_sync[0], bus.enc_b};
      prev_q <= cur_q;
    end
  end

  quad_step_decode u_decode (
    .prev (prev_q),
    .cur  (cur_q),
    .step (step_code)
  );

  // PRIME lets prev_q settle on a resting nonzero state before anything counts.
  always_ff @(posedge clk1) begin
    if (rst) begin
      state     <= PRIME;
      prime_cnt <= '0;
    end else begin
      state     <= state_nxt;
      prime_cnt <= (state == PRIME) ? prime_cnt + 2'd1 : prime_cnt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == PRIME && prime_cnt == 2'(PRIME_CYCLES - 1))
      state_nxt = RUN;
  end

  always_comb begin
    counting = 1'b0;
    if (state == RUN)
      counting = 1'b1;
  end

  assign step_fwd = counting && (step_code == STEP_FWD);
  assign step_rev = counting && (step_code == STEP_REV);
  assign step_ill = counting && (step_code == STEP_ILL);

  always_ff @(posedge clk1) begin
    if (rst) begin
      pos     <= '0;
      enc_err <= 1'b0;
    end else begin
      if (bus.clr_pos)
        pos <= '0;
      else if (step_fwd)
        pos <= pos + 1'b1;
      else if (step_rev)
        pos <= pos - 1'b1;

      if (step_ill)
        enc_err <= 1'b1;
      else if (bus.err_clr)
        enc_err <= 1'b0;
    end
  end

  assign win_end = (win_cnt == WIN_W'(GATE_CYCLES - 1));

  always_comb begin
    acc_step = '0;
    if (step_fwd)
      acc_step = ONE;
    else if (step_rev)
      acc_step = -ONE;
    acc_next = acc + acc_step;
    if ((step_fwd && acc == ACC_MAX) || (step_rev && acc == ACC_MIN))
      acc_next = acc;
    acc_neg = -acc;
    acc_abs = acc[CNT_W] ? acc_neg[CNT_W-1:0] : acc[CNT_W-1:0];
    idle_next = '0;
    if (acc == '0)
      idle_next = (idle_cnt == IDLE_W'(STALL_WINDOWS)) ? idle_cnt : idle_cnt + 1'b1;
  end

  // A step decoded in the terminal cycle seeds the next window's accumulator.
  always_ff @(posedge clk1) begin
    if (rst) begin
      win_cnt   <= '0;
      acc       <= '0;
      idle_cnt  <= '0;
      speed     <= '0;
      dir       <= 1'b1;
      spd_valid <= 1'b0;
      stalled   <= 1'b0;
    end else begin
      spd_valid <= win_end;
      if (win_end) begin
        win_cnt  <= '0;
        acc      <= acc_step;
        idle_cnt <= idle_next;
        speed    <= acc_abs;
        stalled  <= (idle_next == IDLE_W'(STALL_WINDOWS));
        if (acc != '0)
          dir <= ~acc[CNT_W];
      end else begin
        win_cnt <= win_cnt + 1'b1;
        acc     <= acc_next;
      end
    end
  end

  assign bus.pos       = pos;
  assign bus.speed     = speed;
  assign bus.dir       = dir;
  assign bus.spd_valid = spd_valid;
  assign bus.stalled   = stalled;
  assign bus.enc_err   = enc_err;

endmodule

`default_nettype wire

// File: tb/tb_wheel_encoder_reader.sv
// ============================================================================
// tb_wheel_encoder_reader : directed checks of position, speed, errors, stall
// Revision                : 1.0
// ============================================================================
`default_nettype none

module tb_wheel_encoder_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wheel_encoder_reader_if #(.CNT_W(6), .POS_W(12)) bus ();

  wheel_encoder_reader #(
    .GATE_CYCLES   (100),
    .CNT_W         (6),
    .POS_W         (12),
    .STALL_WINDOWS (2)
  ) dut (
    .clk1 (clk),
    .rst  (rst),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]  ab;
    logic        ec;
    logic [11:0] exp_pos;
    logic        exp_err;
  } vec_t;

  vec_t       tbl[12];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  logic [1:0] ab    = 2'b11;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  function automatic logic [1:0] nxt(input logic [1:0] s, input bit f);
    logic [1:0] n;
    case (s)
      2'b00:   n = f ? 2'b01 : 2'b10;
      2'b01:   n = f ? 2'b11 : 2'b00;
      2'b11:   n = f ? 2'b10 : 2'b01;
      default: n = f ? 2'b00 : 2'b11;
    endcase
    return n;
  endfunction

  task automatic set_ab(input logic [1:0] v);
    ab        = v;
    bus.enc_a = v[1];
    bus.enc_b = v[0];
  endtask

  // Bounded wait for the window pulse, then checks its timing and payload.
  task automatic wait_valid(input int exp_cyc, input logic [5:0] exp_spd,
                            input logic exp_dir, input logic exp_stall, input string tag);
    int n = 0;
    while (!bus.spd_valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, " spd_valid"}, bus.spd_valid, 1);
    chk({tag, " valid cycle"}, cyc, exp_cyc);
    chk({tag, " speed"}, bus.speed, exp_spd);
    chk({tag, " dir"}, bus.dir, exp_dir);
    chk({tag, " stalled"}, bus.stalled, exp_stall);
    tick();
    chk({tag, " pulse width"}, bus.spd_valid, 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " pos"}, bus.pos, 0);
    chk({tag, " speed"}, bus.speed, 0);
    chk({tag, " dir"}, bus.dir, 1);
    chk({tag, " spd_valid"}, bus.spd_valid, 0);
    chk({tag, " stalled"}, bus.stalled, 0);
    chk({tag, " enc_err"}, bus.enc_err, 0);
  endtask

  initial begin
    // Decode table, starting from pins 00 with pos = -80.
    tbl[0]  = '{2'b01, 1'b0, 12'hFB1, 1'b0};
    tbl[1]  = '{2'b11, 1'b0, 12'hFB2, 1'b0};
    tbl[2]  = '{2'b01, 1'b0, 12'hFB1, 1'b0};
    tbl[3]  = '{2'b00, 1'b0, 12'hFB0, 1'b0};
    tbl[4]  = '{2'b10, 1'b0, 12'hFAF, 1'b0};
    tbl[5]  = '{2'b10, 1'b0, 12'hFAF, 1'b0};
    tbl[6]  = '{2'b01, 1'b0, 12'hFAF, 1'b1};
    tbl[7]  = '{2'b11, 1'b0, 12'hFB0, 1'b1};
    tbl[8]  = '{2'b11, 1'b1, 12'hFB0, 1'b0};
    tbl[9]  = '{2'b00, 1'b0, 12'hFB0, 1'b1};
    tbl[10] = '{2'b01, 1'b1, 12'hFB1, 1'b0};
    tbl[11] = '{2'b01, 1'b0, 12'hFB1, 1'b0};

    bus.clr_pos = 1'b0;
    bus.err_clr = 1'b0;
    set_ab(2'b11);

    // Wheel resting at 11 through reset, then ten forward steps.
    tick(); tick(); tick();
    chk_reset("reset");
    rst = 1'b0;
    cyc = 0;
    wait_until(5);
    for (int i = 0; i < 10; i++) begin
      set_ab(nxt(ab, 1'b1));
      repeat (4) tick();
    end
    wait_until(50);
    chk("fwd10 pos", bus.pos, 10);
    chk("fwd10 enc_err", bus.enc_err, 0);
    wait_valid(100, 6'd10, 1'b1, 1'b0, "win1");

    // Clear, then 80 reverse steps back to back.
    bus.clr_pos = 1'b1;
    tick();
    bus.clr_pos = 1'b0;
    chk("clr pos", bus.pos, 0);
    for (int i = 0; i < 80; i++) begin
      set_ab(nxt(ab, 1'b0));
      tick();
    end
    wait_until(190);
    chk("rev80 pos", bus.pos, 32'hFB0);
    wait_valid(200, 6'd63, 1'b0, 1'b0, "win2 saturate");

    for (int i = 0; i < 12; i++) begin
      set_ab(tbl[i].ab);
      bus.err_clr = tbl[i].ec;
      tick();
      bus.err_clr = 1'b0;
      repeat (3) tick();
      chk($sformatf("vec%0d pos", i), bus.pos, {20'd0, tbl[i].exp_pos});
      chk($sformatf("vec%0d enc_err", i), bus.enc_err, {31'd0, tbl[i].exp_err});
    end

    // Illegal 01->10, then illegal 10->01 colliding with err_clr.
    set_ab(2'b10);
    repeat (4) tick();
    chk("ill pos held", bus.pos, 32'hFB1);
    chk("ill enc_err", bus.enc_err, 1);
    set_ab(2'b01);
    tick(); tick();
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err set beats clr", bus.enc_err, 1);
    bus.err_clr = 1'b1;
    tick();
    bus.err_clr = 1'b0;
    chk("err_clr alone", bus.enc_err, 0);
    set_ab(nxt(ab, 1'b0));
    repeat (4) tick();
    set_ab(nxt(ab, 1'b0));
    repeat (4) tick();
    chk("win3 pos", bus.pos, 32'hFAF);
    wait_valid(300, 6'd1, 1'b0, 1'b0, "win3");

    // Two idle windows: dir must hold at reverse.
    wait_valid(400, 6'd0, 1'b0, 1'b0, "idle1");
    wait_valid(500, 6'd0, 1'b0, 1'b1, "idle2 stall");
    set_ab(nxt(ab, 1'b1));
    wait_valid(600, 6'd1, 1'b1, 1'b0, "unstall");

    // clr_pos coincident with a forward step at the decoder.
    wait_until(602);
    set_ab(nxt(ab, 1'b1));
    tick(); tick();
    bus.clr_pos = 1'b1;
    tick();
    bus.clr_pos = 1'b0;
    chk("clr beats step", bus.pos, 0);
    for (int i = 0; i < 3; i++) begin
      set_ab(nxt(ab, 1'b0));
      repeat (4) tick();
    end
    chk("after clr pos", bus.pos, 32'hFFD);
    wait_valid(700, 6'd2, 1'b0, 1'b0, "win7 clr");

    // Five steps, then reset mid-window with the wheel resting at 10.
    tick();
    for (int i = 0; i < 5; i++) begin
      set_ab(nxt(ab, 1'b1));
      repeat (4) tick();
    end
    chk("pre-reset pos", bus.pos, 2);
    wait_until(730);
    rst = 1'b1;
    tick(); tick();
    chk_reset("mid reset");
    rst = 1'b0;
    cyc = 0;
    wait_valid(100, 6'd0, 1'b1, 1'b0, "post reset");
    chk("post reset pos", bus.pos, 0);
    chk("post reset enc_err", bus.enc_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wheel_encoder_reader.md
Name: wheel_encoder_reader

Overview:
Reads the quadrature encoder on one drive wheel and reports position, speed magnitude and direction. It closes the loop around the H-bridge PWM driver. The driver turns direction/speed/enable commands into motor drive; this block turns wheel motion back into direction/speed measurements for the car's control logic. There is one instance per wheel, and it runs entirely in the clk1 domain.

Parameters:
GATE_CYCLES, 50000, speed measurement window in clk1 cycles (1 ms at 50 MHz); legal range is 4 or more.
CNT_W, 16, width of the speed magnitude output.
POS_W, 24, width of the signed position counter.
STALL_WINDOWS, 4, number of consecutive zero-motion windows before stalled asserts.

Ports:
clk1  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
enc_a  in  1  encoder channel A, asynchronous to clk1.
enc_b  in  1  encoder channel B, asynchronous to clk1.
clr_pos  in  1  synchronous clear of pos.
err_clr  in  1  clears sticky enc_err.
pos  out  POS_W  signed position in x4 counts.
speed  out  CNT_W  |net counts| in the last window, saturating.
dir  out  1  1 = forward, 0 = reverse; same polarity as the drive direction command.
spd_valid  out  1  one-cycle pulse when speed/dir/stalled update.
stalled  out  1  no motion for STALL_WINDOWS windows.
enc_err  out  1  sticky illegal-transition flag.

Behaviour:
- Interface: one clock, clk1. Reset rst is synchronous and active-high.
- Reset values: pos=0, speed=0, dir=1, spd_valid=0, stalled=0, enc_err=0. Internal state on reset: synchronizers=0, window counter=0, accumulator=0, idle count=0, FSM=PRIME.
- Reset mid-operation discards the partial window and any pending step.
- Synchronizer: each of A and B passes through a 2-FF synchronizer. The decoder compares the current synced state {A,B} with the previous synced state.
- Pin-to-pos latency is 3 clk1 edges.
- FSM PRIME: lasts 3 cycles after rst deasserts. It loads the previous-state register from the synced value and counts nothing. This prevents a false step or error when the wheel rests at a nonzero state.
- FSM PRIME->RUN transition: automatic after the 3 cycles. The window counter runs during PRIME.
- Step decode, forward sequence: 00->01->11->10->00 gives +1.
- Step decode, reverse sequence: the opposite order gives -1.
- Step decode, unchanged state: 0.
- Step decode, both bits changed: illegal. Count 0, set enc_err. The previous-state register still updates.
- enc_err: sticky. It clears on err_clr. If err_clr and a new illegal step occur in the same cycle, set wins.
- pos: adds the step each RUN cycle with two's-complement wrap at POS_W.
- clr_pos: pos=0 on the next edge. If a step occurs in the same cycle, the clear wins and that step is lost from pos; it still counts toward speed.
- Window counter: runs 0..GATE_CYCLES-1 and wraps.
- Speed accumulator: signed, CNT_W+1 bits, saturating at ±(2^CNT_W-1).
- Window end, outputs: at the terminal count, speed=|acc| and spd_valid=1 for exactly one cycle.
- Window end, dir: dir=1 if acc>0, dir=0 if acc<0, held if acc=0.
- Window end, accumulator: acc is reloaded with that cycle's step, so a terminal-cycle step counts toward the next window.
- Stall detect: the idle count increments, saturating, on each window with acc=0. It clears on a nonzero window.
- stalled: asserts when the idle count reaches STALL_WINDOWS and clears when the idle count clears. It updates only alongside spd_valid.
- The first window after reset is GATE_CYCLES cycles measured from rst deassertion.

Decomposition:
- Package encoder_pkg holds the following constants:
  - quadrature state encodings Q00, Q01, Q11, Q10;
  - 2-bit step codes STEP_NONE, STEP_FWD, STEP_REV, STEP_ILL;
  - FSM states PRIME and RUN.
- Sub-module quad_step_decode: a combinational mapping from (prev, cur) to a step code. It is reused by the planned steering-angle encoder.
- Synchronizer, counters and FSM stay in wheel_encoder_reader.

Test Plan:
All scenarios use GATE_CYCLES=100, CNT_W=6, POS_W=12 and STALL_WINDOWS=2.
1. Hold A=B=1 through reset, then apply 10 forward steps 4 cycles apart, all within the first window -> enc_err=0, pos=10; spd_valid pulses at cycle 100 after rst release with speed=10, dir=1.
2. Apply 80 reverse steps, one per cycle, within one window -> speed=63 (saturated), dir=0, pos=-80 (0xFB0).
3. Apply an illegal jump 00->11 -> enc_err=1, pos unchanged; err_clr pulse -> enc_err=0; err_clr in the same cycle as another illegal step -> enc_err stays 1.
4. Give no edges for 2 windows -> stalled=1 at the second spd_valid with speed=0 and dir held; then 1 forward step -> next spd_valid gives speed=1, dir=1, stalled=0.
5. Assert clr_pos in the same cycle a forward step reaches the decoder -> pos=0, and the window's speed still includes that step.
6. After 5 steps, assert rst mid-window -> all outputs return to reset values; the next spd_valid arrives exactly 100 cycles after rst release and reports speed=0.
